// File: rtl/proc_pkg.sv
// Shared processor types for the fetch stage: word/address widths,
// queue entry layout and fetch FSM state encoding.
package proc_pkg;

    localparam int WORD_W = 8;
    localparam int OP_W   = 3;
    localparam int AW     = WORD_W - OP_W;

    typedef logic [AW-1:0]     addr_t;
    typedef logic [WORD_W-1:0] word_t;

    typedef struct packed {
        addr_t pc;
        word_t instr;
    } fq_entry_t;

    typedef enum logic {
        START = 1'b0,
        RUN   = 1'b1
    } fq_state_t;

    // Sequential PC step; wraps naturally at 2^AW.
    function automatic addr_t pc_next(input addr_t pc);
        return pc + addr_t'(1);
    endfunction

endpackage

// File: rtl/fetch_queue_buffer.sv
// fq_buffer: DEPTH-entry circular buffer of fetched words.
// Flush wins over push/pop and empties the buffer in one cycle.
module fq_buffer
    import proc_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  fq_entry_t     wdata,
    output fq_entry_t     head,
    output logic [CW-1:0] count,
    output logic          full
);

    fq_entry_t      mem [DEPTH];
    logic [PW-1:0]  rd;
    logic [PW-1:0]  wr;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign head = mem[rd];
    assign full = (count == CW'(DEPTH));

    // Storage, pointers and occupancy; flush discards everything still held.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wr] <= wdata;
                wr      <= ptr_inc(wr);
            end
            if (pop) rd <= ptr_inc(rd);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Occupancy must stay within 0..DEPTH.
    a_no_overflow: assert property (@(posedge clock) disable iff (reset)
        !(push && !pop && !flush && full));
    a_no_underflow: assert property (@(posedge clock) disable iff (reset)
        !(pop && (count == '0)));

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: drives the ROM address from the PC, captures {PC, Idata}
// into a small prefetch queue and hands words to decode over valid/ready.
// Branch redirects flush the queue and reload the PC.
// Optional: define FETCH_STATS_EN to add saturating fetch/stall counters.
module fetch_queue
    import proc_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clock,
    input  logic              reset,
    output logic [AW-1:0]     Iaddress,
    input  logic [WORD_W-1:0] Idata,
    input  logic              en,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic [WORD_W-1:0] ir_data,
    output logic [AW-1:0]     ir_pc,
    input  logic              br_take,
    input  logic [AW-1:0]     br_target
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0]       fetch_cnt,
    output logic [15:0]       stall_cnt
`endif
);

    localparam int CW = $clog2(DEPTH + 1);

    fq_state_t     state;
    fq_state_t     state_nxt;
    logic          running;
    addr_t         pc;
    logic          push;
    logic          pop;
    logic          full;
    logic [CW-1:0] count;
    fq_entry_t     head;
    fq_entry_t     wdata;

    assign Iaddress = pc;
    assign ir_valid = (count != '0);
    assign ir_data  = head.instr;
    assign ir_pc    = head.pc;
    assign pop      = ir_valid & ir_ready;
    assign wdata    = '{pc: pc, instr: Idata};

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= START;
        else       state <= state_nxt;
    end

    // FSM next state: START lasts one cycle; a redirect always lands in RUN.
    always_comb begin
        state_nxt = state;
        if (br_take) begin
            state_nxt = RUN;
        end else begin
            case (state)
                START:   state_nxt = RUN;
                RUN:     state_nxt = RUN;
                default: state_nxt = START;
            endcase
        end
    end

    // FSM outputs: pushes only in RUN, never during a redirect; a full
    // queue may still accept a word when the head leaves this cycle.
    always_comb begin
        running = (state == RUN);
        push    = running & en & ~br_take & (~full | pop);
    end

    // PC: redirect target has priority, otherwise advance on each push.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)        pc <= '0;
        else if (br_take) pc <= br_target;
        else if (push)    pc <= pc_next(pc);
    end

    fq_buffer #(.DEPTH(DEPTH)) u_buf (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (br_take),
        .wdata (wdata),
        .head  (head),
        .count (count),
        .full  (full)
    );

`ifdef FETCH_STATS_EN
    logic stall;
    assign stall = running & en & ~br_take & full & ~pop;

    // Saturating counters of pushes and of full-queue stall cycles.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (push && fetch_cnt != 16'hFFFF)  fetch_cnt <= fetch_cnt + 16'd1;
            if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a queue-based reference model
// tracks the expected head, PC and counters from the fetch rules.
module tb_fetch_queue;
    import proc_pkg::*;

    localparam int DEPTH = 2;

    logic        clock;
    logic        reset;
    addr_t       Iaddress;
    word_t       Idata;
    logic        en;
    logic        ir_valid;
    logic        ir_ready;
    word_t       ir_data;
    addr_t       ir_pc;
    logic        br_take;
    addr_t       br_target;
`ifdef FETCH_STATS_EN
    logic [15:0] fetch_cnt;
    logic [15:0] stall_cnt;
`endif

    word_t rom [32];
    assign Idata = rom[Iaddress];

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .Iaddress  (Iaddress),
        .Idata     (Idata),
        .en        (en),
        .ir_valid  (ir_valid),
        .ir_ready  (ir_ready),
        .ir_data   (ir_data),
        .ir_pc     (ir_pc),
        .br_take   (br_take),
        .br_target (br_target)
`ifdef FETCH_STATS_EN
        ,
        .fetch_cnt (fetch_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: a plain queue of fetched words plus the PC.
    typedef struct {
        int pc;
        int w;
    } ment_t;
    ment_t mq[$];
    int    popped[$];
    int    mpc;
    bit    mrun;
    int    mfetch;
    int    mstall;

    task automatic model_reset();
        mq.delete();
        mpc    = 0;
        mrun   = 0;
        mfetch = 0;
        mstall = 0;
    endtask

    // Called at a falling edge: check outputs, drive inputs, advance model
    // to what the next rising edge produces, then wait for the next fall.
    task automatic step(input bit e, input bit r, input bit b, input int t);
        bit pop, push, full, stall;
        checks++;
        if (ir_valid !== (mq.size() != 0)) begin
            errors++;
            $display("FAIL ir_valid: got %0b want %0b", ir_valid, mq.size() != 0);
        end
        checks++;
        if (Iaddress !== addr_t'(mpc)) begin
            errors++;
            $display("FAIL Iaddress: got %0d want %0d", Iaddress, mpc);
        end
        if (mq.size() != 0) begin
            checks++;
            if (ir_pc !== addr_t'(mq[0].pc)) begin
                errors++;
                $display("FAIL ir_pc: got %0d want %0d", ir_pc, mq[0].pc);
            end
            checks++;
            if (ir_data !== word_t'(mq[0].w)) begin
                errors++;
                $display("FAIL ir_data: got %0h want %0h", ir_data, mq[0].w);
            end
        end
`ifdef FETCH_STATS_EN
        checks++;
        if (fetch_cnt !== 16'(mfetch)) begin
            errors++;
            $display("FAIL fetch_cnt: got %0d want %0d", fetch_cnt, mfetch);
        end
        checks++;
        if (stall_cnt !== 16'(mstall)) begin
            errors++;
            $display("FAIL stall_cnt: got %0d want %0d", stall_cnt, mstall);
        end
`endif
        en        = e;
        ir_ready  = r;
        br_take   = b;
        br_target = addr_t'(t);
        pop   = (mq.size() != 0) && r;
        full  = (mq.size() == DEPTH);
        push  = mrun && e && !b && (!full || pop);
        stall = mrun && e && !b && full && !pop;
        if (pop) begin
            popped.push_back(mq[0].pc);
            void'(mq.pop_front());
        end
        if (b) begin
            mq.delete();
            mpc = t % 32;
        end else if (push) begin
            mq.push_back('{pc: mpc, w: int'(rom[mpc])});
            mpc = (mpc + 1) % 32;
        end
        mrun = 1;
        if (push && mfetch < 65535)  mfetch++;
        if (stall && mstall < 65535) mstall++;
        @(negedge clock);
    endtask

    task automatic do_reset();
        en = 0; ir_ready = 0; br_take = 0; br_target = '0;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        model_reset();
        popped.delete();
    endtask

    task automatic test_reset();
        en = 0; ir_ready = 0; br_take = 0; br_target = '0;
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (ir_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", ir_valid); end
        checks++;
        if (Iaddress !== '0) begin errors++; $display("FAIL reset_iaddr: got %0d want 0", Iaddress); end
        checks++;
        if (ir_data !== '0) begin errors++; $display("FAIL reset_data: got %0h want 0", ir_data); end
        checks++;
        if (ir_pc !== '0) begin errors++; $display("FAIL reset_pc: got %0d want 0", ir_pc); end
        do_reset();
    endtask

    task automatic test_stream();
        int first = -1;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            if (first < 0 && ir_valid === 1'b1) first = i;
            step(1, 1, 0, 0);
        end
        checks++;
        if (first != 2) begin errors++; $display("FAIL first_valid_cycle: got %0d want 2", first); end
        checks++;
        if (popped.size() != 6) begin
            errors++; $display("FAIL stream_pops: got %0d want 6", popped.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (popped[k] != k) begin errors++; $display("FAIL stream_order: got %0d want %0d", popped[k], k); end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
        checks++;
        if (Iaddress !== addr_t'(2)) begin errors++; $display("FAIL bp_pc_hold: got %0d want 2", Iaddress); end
        for (int i = 0; i < 6; i++) step(1, 1, 0, 0);
        checks++;
        if (popped.size() < 3) begin
            errors++; $display("FAIL bp_drain: got %0d pops want >=3", popped.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (popped[k] != k) begin errors++; $display("FAIL bp_order: got %0d want %0d", popped[k], k); end
            end
        end
    endtask

    task automatic test_wrap();
        bit seen = 0;
        do_reset();
        for (int i = 0; i < 40; i++) step(1, 1, 0, 0);
        for (int k = 1; k < popped.size(); k++)
            if (popped[k-1] == 31 && popped[k] == 0) seen = 1;
        checks++;
        if (!seen) begin errors++; $display("FAIL pc_wrap: got no 31->0 want 31->0"); end
    endtask

    task automatic test_redirect();
        int  n;
        bit  found = 0;
        do_reset();
        for (int i = 0; i < 20 && !found; i++) begin
            if (mq.size() != 0 && mq[0].pc == 3) found = 1;
            else step(1, 1, 0, 0);
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL redir_setup: got no head pc 3 want head pc 3");
        end else begin
            step(1, 0, 0, 0);                 // queue now holds pc 3,4
            checks++;
            if (ir_pc !== addr_t'(3) || ir_valid !== 1'b1) begin
                errors++; $display("FAIL redir_head: got %0d/%0b want 3/1", ir_pc, ir_valid);
            end
            n = popped.size();
            step(1, 1, 1, 1);                 // cycle N
            checks++;
            if (ir_valid !== 1'b0) begin errors++; $display("FAIL redir_n1_valid: got %0b want 0", ir_valid); end
            checks++;
            if (Iaddress !== addr_t'(1)) begin errors++; $display("FAIL redir_n1_iaddr: got %0d want 1", Iaddress); end
            step(1, 1, 0, 0);                 // cycle N+1
            checks++;
            if (ir_valid !== 1'b1 || ir_pc !== addr_t'(1)) begin
                errors++; $display("FAIL redir_n2: got %0b/%0d want 1/1", ir_valid, ir_pc);
            end
            step(1, 1, 0, 0);
            step(1, 1, 0, 0);
            checks++;
            if (popped.size() < n + 2 || popped[n] != 3 || popped[n+1] != 1) begin
                errors++; $display("FAIL redir_order: got size %0d want 3 then 1 with 4 dropped", popped.size() - n);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (ir_valid !== 1'b0) begin errors++; $display("FAIL async_valid: got %0b want 0", ir_valid); end
        checks++;
        if (Iaddress !== '0) begin errors++; $display("FAIL async_iaddr: got %0d want 0", Iaddress); end
        checks++;
        if (dut.u_buf.count !== '0) begin errors++; $display("FAIL async_count: got %0d want 0", dut.u_buf.count); end
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        popped.delete();
        for (int i = 0; i < 6; i++) step(1, 1, 0, 0);
        checks++;
        if (popped.size() == 0 || popped[0] != 0) begin
            errors++; $display("FAIL async_restart: got %0d pops want first pc 0", popped.size());
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            bit e, r, b;
            e = ($urandom_range(0, 9) < 8);
            r = ($urandom_range(0, 9) < 7);
            b = ($urandom_range(0, 99) < 8);
            step(e, r, b, int'($urandom_range(0, 31)));
        end
    endtask

`ifdef FETCH_STATS_EN
    task automatic test_stats_sat();
        do_reset();
        for (int i = 0; i < 70000; i++) step(1, 1, 0, 0);
        checks++;
        if (fetch_cnt !== 16'hFFFF) begin errors++; $display("FAIL fetch_sat: got %0h want ffff", fetch_cnt); end
    endtask
`endif

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = word_t'($urandom);
        test_reset();
        test_stream();
        test_backpressure();
        test_wrap();
        test_redirect();
        test_async_reset();
        test_random();
`ifdef FETCH_STATS_EN
        test_stats_sat();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
